// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator and its sequencer.
// State encoding, counter sizing helper and one-hot result codes {gt, lt, eq}.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_mag_comparator.sv
// Folds MSB-first per-bit gt/lt/eq triples into a registered word-level magnitude relation.
// Latency: done pulses the cycle after the WIDTH-th accepted bit (start-to-done >= WIDTH+1 cycles).
// Backpressure: none; bits are consumed whenever bit_valid is high in RUN, bubbles of any length allowed.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic greater,
    input  logic lesser,
    input  logic equal,
    output logic busy,
    output logic done,
    output logic a_gt_b,
    output logic a_lt_b,
    output logic a_eq_b,
    output logic err
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    cmp_state_t    state;
    logic [CW-1:0] cnt;
    logic          decided;

    logic one_hot;
    logic bit_gt;
    logic bit_lt;

    // A malformed triple counts as an equal bit, so it can never decide the result.
    assign one_hot = ($countones({greater, lesser, equal}) == 1);
    assign bit_gt  = one_hot & greater;
    assign bit_lt  = one_hot & lesser;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            decided <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            a_gt_b  <= 1'b0;
            a_lt_b  <= 1'b0;
            a_eq_b  <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        cnt     <= CNT_LOAD;
                        decided <= 1'b0;
                        a_gt_b  <= 1'b0;
                        a_lt_b  <= 1'b0;
                        a_eq_b  <= 1'b0;
                        err     <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (bit_valid) begin
                        if (!one_hot) begin
                            err <= 1'b1;
                        end
                        if (!decided && bit_gt) begin
                            a_gt_b  <= 1'b1;
                            decided <= 1'b1;
                        end
                        if (!decided && bit_lt) begin
                            a_lt_b  <= 1'b1;
                            decided <= 1'b1;
                        end
                        if (cnt == CNT_ONE) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            a_eq_b <= !(decided || bit_gt || bit_lt);
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator (WIDTH=8) using immediate assertions per check.
module tb_serial_mag_comparator;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic bit_valid;
    logic greater;
    logic lesser;
    logic equal;
    logic busy;
    logic done;
    logic a_gt_b;
    logic a_lt_b;
    logic a_eq_b;
    logic err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_mag_comparator #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .greater   (greater),
        .lesser    (lesser),
        .equal     (equal),
        .busy      (busy),
        .done      (done),
        .a_gt_b    (a_gt_b),
        .a_lt_b    (a_lt_b),
        .a_eq_b    (a_eq_b),
        .err       (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [5:0] exp);
        chk(tag, {busy, done, a_gt_b, a_lt_b, a_eq_b, err}, {26'd0, exp});
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feeds the 8 bit-pairs of a vs b MSB-first; inj marks a bit replaced by an illegal
    // gt+lt triple, gap inserts bubbles (carrying junk) before each bit after the first,
    // start_at raises start together with that bit.
    task automatic run_bits(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input int inj, input int gap, input int start_at);
        int early = 0;
        int notbusy = 0;
        for (int i = 7; i >= 0; i--) begin
            if (i < 7) begin
                for (int g = 0; g < gap; g++) begin
                    bit_valid = 1'b0;
                    greater = 1'b1; lesser = 1'b0; equal = 1'b0;
                    tick();
                    if (done) early++;
                    if (!busy) notbusy++;
                end
            end
            bit_valid = 1'b1;
            greater = a[i] & ~b[i];
            lesser  = ~a[i] & b[i];
            equal   = (a[i] == b[i]);
            if (i == inj) begin
                greater = 1'b1; lesser = 1'b1; equal = 1'b0;
            end
            start = (i == start_at);
            tick();
            start = 1'b0;
            if (i > 0) begin
                if (done) early++;
                if (!busy) notbusy++;
            end
        end
        bit_valid = 1'b0;
        greater = 1'b0; lesser = 1'b0; equal = 1'b0;
        chk({tag, "_no_early_done"}, early, 0);
        chk({tag, "_busy_held"}, notbusy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bit_valid = 1'b0;
        greater = 1'b0;
        lesser = 1'b0;
        equal = 1'b0;
        tick();
        tick();
        // {busy, done, gt, lt, eq, err}
        chk_out("reset", 6'b000000);
        rst_n = 1'b1;
        tick();
        chk_out("idle_after_reset", 6'b000000);

        // Equal operands, contiguous bits: done after the 9th edge from start.
        do_start();
        chk_out("eq_started", 6'b100000);
        run_bits("eq", 8'hA5, 8'hA5, -1, 0, -1);
        chk_out("eq_done", 6'b010010);
        tick();
        chk_out("eq_hold", 6'b000010);

        // Stray bit_valid in IDLE must not disturb held results.
        bit_valid = 1'b1; greater = 1'b1;
        tick();
        bit_valid = 1'b0; greater = 1'b0;
        chk_out("idle_bits_ignored", 6'b000010);

        do_start();
        chk_out("gt_started", 6'b100000);
        run_bits("gt", 8'h80, 8'h7F, -1, 0, -1);
        chk_out("gt_done", 6'b011000);

        do_start();
        run_bits("lt_lsb", 8'h12, 8'h13, -1, 0, -1);
        chk_out("lt_lsb_done", 6'b010100);

        // Bubbles of two cycles between bits, bubble lanes carry a junk greater.
        do_start();
        run_bits("bubble", 8'h3C, 8'h3D, -1, 2, -1);
        chk_out("bubble_done", 6'b010100);

        // Illegal triple on bit 3 of an equal stream.
        do_start();
        run_bits("inj", 8'h55, 8'h55, 3, 0, -1);
        chk_out("inj_done", 6'b010011);
        tick();
        chk_out("inj_hold", 6'b000011);
        do_start();
        chk_out("inj_err_cleared", 6'b100000);
        run_bits("after_inj", 8'h00, 8'h01, -1, 0, -1);
        chk_out("after_inj_done", 6'b010100);

        // Reset four bits into a run that has already decided.
        do_start();
        for (int i = 7; i >= 4; i--) begin
            bit_valid = 1'b1;
            greater = 1'b1; lesser = 1'b0; equal = 1'b0;
            tick();
        end
        bit_valid = 1'b0; greater = 1'b0;
        chk_out("mid_run_decided", 6'b101000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_out("mid_run_reset", 6'b000000);
        tick();
        chk_out("no_done_after_reset", 6'b000000);
        do_start();
        run_bits("post_reset", 8'h01, 8'h00, -1, 0, -1);
        chk_out("post_reset_done", 6'b011000);

        // start mid-RUN ignored, start in DONE launches the next comparison at once.
        do_start();
        run_bits("start_in_run", 8'hC3, 8'hC2, -1, 0, 4);
        chk_out("start_in_run_done", 6'b011000);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("start_in_done", 6'b100000);
        run_bits("b2b", 8'h00, 8'hFF, -1, 0, -1);
        chk_out("b2b_done", 6'b010100);
        tick();
        chk_out("b2b_hold", 6'b000100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
